// File: rtl/gpio_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the v2 GPIO controller: register map, CTRL bits and
// the output-register update helper used by the atomic set/clear/toggle ports.
package gpio_pkg;

    localparam logic [31:0] GPIO_V2_IN      = 32'h0000_0000;
    localparam logic [31:0] GPIO_V2_OUT     = 32'h0000_0004;
    localparam logic [31:0] GPIO_V2_OE      = 32'h0000_0008;
    localparam logic [31:0] GPIO_V2_INTE    = 32'h0000_000C;
    localparam logic [31:0] GPIO_V2_PTRIG   = 32'h0000_0010;
    localparam logic [31:0] GPIO_V2_ETRIG   = 32'h0000_0014;
    localparam logic [31:0] GPIO_V2_BOTH    = 32'h0000_0018;
    localparam logic [31:0] GPIO_V2_AUX     = 32'h0000_001C;
    localparam logic [31:0] GPIO_V2_CTRL    = 32'h0000_0020;
    localparam logic [31:0] GPIO_V2_INTS    = 32'h0000_0024;
    localparam logic [31:0] GPIO_V2_OUT_SET = 32'h0000_0028;
    localparam logic [31:0] GPIO_V2_OUT_CLR = 32'h0000_002C;
    localparam logic [31:0] GPIO_V2_OUT_TGL = 32'h0000_0030;
    localparam logic [31:0] GPIO_V2_DEB_PER = 32'h0000_0034;
    localparam logic [31:0] GPIO_V2_DEB_EN  = 32'h0000_0038;

    localparam int unsigned GPIO_V2_CTRL_INTE = 0;

    typedef enum logic [1:0] {
        GPIO_OUT_WR,
        GPIO_OUT_SET,
        GPIO_OUT_CLR,
        GPIO_OUT_TGL
    } gpio_out_op_e;

    // Word-aligned match; byte-lane bits [1:0] never take part in decode.
    function automatic logic gpio_addr_hit(input logic [31:0] addr,
                                           input logic [31:0] off);
        return addr[31:2] == off[31:2];
    endfunction

    function automatic logic [31:0] gpio_out_update(input logic [31:0]  cur,
                                                    input logic [31:0]  d,
                                                    input gpio_out_op_e op);
        logic [31:0] nxt;
        case (op)
            GPIO_OUT_WR:  nxt = d;
            GPIO_OUT_SET: nxt = cur | d;
            GPIO_OUT_CLR: nxt = cur & ~d;
            GPIO_OUT_TGL: nxt = cur ^ d;
            default:      nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/gpio_ctrl_v2_if.sv
`timescale 1ns/1ps
// System register bus port of the v2 GPIO controller; read data is
// combinational on the address.
interface gpio_ctrl_v2_if;

    logic        gpio_we;
    logic [31:0] gpio_addr;
    logic [31:0] gpio_data_i;
    logic [31:0] gpio_data_o;

    modport master (
        output gpio_we,
        output gpio_addr,
        output gpio_data_i,
        input  gpio_data_o
    );

    modport slave (
        input  gpio_we,
        input  gpio_addr,
        input  gpio_data_i,
        output gpio_data_o
    );

endinterface

// File: rtl/gpio_in_filter.sv
`timescale 1ns/1ps
// Pad input conditioning: multi-stage synchroniser, shared debounce tick
// counter and per-pin two-tick agreement debounce.
module gpio_in_filter
    import gpio_pkg::*;
#(
    parameter int unsigned GPIO_W      = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CNT_W   = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [GPIO_W-1:0]    in_pad_i,
    input  logic [DEB_CNT_W-1:0] deb_per,
    input  logic                 deb_per_wr,
    input  logic [GPIO_W-1:0]    deb_en,
    output logic [GPIO_W-1:0]    filt
);

    logic [SYNC_STAGES-1:0][GPIO_W-1:0] sync_q;
    logic [GPIO_W-1:0]                  sync;
    logic [DEB_CNT_W-1:0]               cnt_q;
    logic                               deb_on;
    logic                               tick;
    logic [GPIO_W-1:0]                  active;
    logic [GPIO_W-1:0]                  upd;
    logic [GPIO_W-1:0]                  agree;
    logic [GPIO_W-1:0]                  cand_q;
    logic [GPIO_W-1:0]                  deb_q;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= in_pad_i;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync   = sync_q[SYNC_STAGES-1];
    assign deb_on = (deb_per != '0);
    assign tick   = deb_on && (cnt_q >= deb_per);

    // Counter idles at zero while bypassed so a new period starts cleanly.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            cnt_q <= '0;
        end else if (deb_per_wr || tick || !deb_on) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DEB_CNT_W'(1);
        end
    end

    assign active = deb_en & {GPIO_W{deb_on}};
    assign upd    = active & {GPIO_W{tick}};
    assign agree  = ~(sync ^ cand_q);

    // deb only follows sync when two consecutive ticks saw the same value.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            cand_q <= '0;
            deb_q  <= '0;
        end else begin
            cand_q <= (cand_q & ~upd) | (sync & upd);
            deb_q  <= (deb_q & ~(upd & agree)) | (sync & upd & agree);
        end
    end

    assign filt = (active & deb_q) | (~active & sync);

endmodule

// File: rtl/gpio_ctrl_v2.sv
`timescale 1ns/1ps
// Next-generation GPIO controller: register file, interrupt event logic,
// read mux and auxiliary output mux around the input filter.
module gpio_ctrl_v2
    import gpio_pkg::*;
#(
    parameter int unsigned GPIO_W      = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CNT_W   = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    gpio_ctrl_v2_if.slave     bus,
    input  logic [GPIO_W-1:0] in_pad_i,
    input  logic [GPIO_W-1:0] aux_i,
    output logic [GPIO_W-1:0] out_pad_o,
    output logic [GPIO_W-1:0] oen_padoe_o,
    output logic              gpio_inta_o
);

    logic [GPIO_W-1:0]    out_q, oe_q, inte_q, ptrig_q, etrig_q, both_q, aux_q;
    logic [GPIO_W-1:0]    ints_q, deb_en_q, filt, filt_q;
    logic [DEB_CNT_W-1:0] deb_per_q;
    logic                 ctrl_q;
    logic                 inta_q;

    logic [GPIO_W-1:0]    wd;
    logic wr_out, wr_oe, wr_inte, wr_ptrig, wr_etrig, wr_both, wr_aux, wr_ctrl;
    logic wr_ints, wr_set, wr_clr, wr_tgl, wr_deb_per, wr_deb_en, out_wr;
    gpio_out_op_e         out_op;
    logic [31:0]          out_ext;
    logic [31:0]          out_upd;
    logic [31:0]          rd_data;

    assign wd = bus.gpio_data_i[GPIO_W-1:0];

    assign wr_out     = bus.gpio_we & gpio_addr_hit(bus.gpio_addr, GPIO_V2_OUT);
    assign wr_oe      = bus.gpio_we & gpio_addr_hit(bus.gpio_addr, GPIO_V2_OE);
    assign wr_inte    = bus.gpio_we & gpio_addr_hit(bus.gpio_addr, GPIO_V2_INTE);
    assign wr_ptrig   = bus.gpio_we & gpio_addr_hit(bus.gpio_addr, GPIO_V2_PTRIG);
    assign wr_etrig   = bus.gpio_we & gpio_addr_hit(bus.gpio_addr, GPIO_V2_ETRIG);
    assign wr_both    = bus.gpio_we & gpio_addr_hit(bus.gpio_addr, GPIO_V2_BOTH);
    assign wr_aux     = bus.gpio_we & gpio_addr_hit(bus.gpio_addr, GPIO_V2_AUX);
    assign wr_ctrl    = bus.gpio_we & gpio_addr_hit(bus.gpio_addr, GPIO_V2_CTRL);
    assign wr_ints    = bus.gpio_we & gpio_addr_hit(bus.gpio_addr, GPIO_V2_INTS);
    assign wr_set     = bus.gpio_we & gpio_addr_hit(bus.gpio_addr, GPIO_V2_OUT_SET);
    assign wr_clr     = bus.gpio_we & gpio_addr_hit(bus.gpio_addr, GPIO_V2_OUT_CLR);
    assign wr_tgl     = bus.gpio_we & gpio_addr_hit(bus.gpio_addr, GPIO_V2_OUT_TGL);
    assign wr_deb_per = bus.gpio_we & gpio_addr_hit(bus.gpio_addr, GPIO_V2_DEB_PER);
    assign wr_deb_en  = bus.gpio_we & gpio_addr_hit(bus.gpio_addr, GPIO_V2_DEB_EN);

    assign out_wr = wr_out | wr_set | wr_clr | wr_tgl;

    always_comb begin
        out_op = GPIO_OUT_WR;
        if (wr_set)      out_op = GPIO_OUT_SET;
        else if (wr_clr) out_op = GPIO_OUT_CLR;
        else if (wr_tgl) out_op = GPIO_OUT_TGL;
        out_ext = '0;
        out_ext[GPIO_W-1:0] = out_q;
        out_upd = gpio_out_update(out_ext, bus.gpio_data_i, out_op);
    end

    gpio_in_filter #(
        .GPIO_W      (GPIO_W),
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CNT_W   (DEB_CNT_W)
    ) u_in_filter (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .in_pad_i   (in_pad_i),
        .deb_per    (deb_per_q),
        .deb_per_wr (wr_deb_per),
        .deb_en     (deb_en_q),
        .filt       (filt)
    );

    logic [GPIO_W-1:0] rise, fall, edge_evt, level_evt, evt;

    assign rise      = filt & ~filt_q;
    assign fall      = ~filt & filt_q;
    assign edge_evt  = (both_q & (rise | fall)) |
                       (~both_q & ((ptrig_q & rise) | (~ptrig_q & fall)));
    assign level_evt = ~(filt ^ ptrig_q);
    assign evt       = (etrig_q & edge_evt) | (~etrig_q & level_evt);

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            out_q     <= '0;
            oe_q      <= '0;
            inte_q    <= '0;
            ptrig_q   <= '0;
            etrig_q   <= '0;
            both_q    <= '0;
            aux_q     <= '0;
            ctrl_q    <= 1'b0;
            ints_q    <= '0;
            deb_per_q <= '0;
            deb_en_q  <= '0;
            filt_q    <= '0;
            inta_q    <= 1'b0;
        end else begin
            if (out_wr)     out_q     <= out_upd[GPIO_W-1:0];
            if (wr_oe)      oe_q      <= wd;
            if (wr_inte)    inte_q    <= wd;
            if (wr_ptrig)   ptrig_q   <= wd;
            if (wr_etrig)   etrig_q   <= wd;
            if (wr_both)    both_q    <= wd;
            if (wr_aux)     aux_q     <= wd;
            if (wr_ctrl)    ctrl_q    <= bus.gpio_data_i[GPIO_V2_CTRL_INTE];
            if (wr_deb_per) deb_per_q <= bus.gpio_data_i[DEB_CNT_W-1:0];
            if (wr_deb_en)  deb_en_q  <= wd;
            // Set is OR-ed in after the clear so a coincident event wins.
            ints_q <= (ints_q & ~(wr_ints ? wd : '0)) | evt;
            filt_q <= filt;
            inta_q <= ctrl_q & |(ints_q & inte_q);
        end
    end

    always_comb begin
        rd_data = '0;
        case (bus.gpio_addr[31:2])
            GPIO_V2_IN[31:2]:      rd_data[GPIO_W-1:0]    = filt;
            GPIO_V2_OUT[31:2]:     rd_data[GPIO_W-1:0]    = out_q;
            GPIO_V2_OE[31:2]:      rd_data[GPIO_W-1:0]    = oe_q;
            GPIO_V2_INTE[31:2]:    rd_data[GPIO_W-1:0]    = inte_q;
            GPIO_V2_PTRIG[31:2]:   rd_data[GPIO_W-1:0]    = ptrig_q;
            GPIO_V2_ETRIG[31:2]:   rd_data[GPIO_W-1:0]    = etrig_q;
            GPIO_V2_BOTH[31:2]:    rd_data[GPIO_W-1:0]    = both_q;
            GPIO_V2_AUX[31:2]:     rd_data[GPIO_W-1:0]    = aux_q;
            GPIO_V2_CTRL[31:2]:    rd_data[GPIO_V2_CTRL_INTE] = ctrl_q;
            GPIO_V2_INTS[31:2]:    rd_data[GPIO_W-1:0]    = ints_q;
            GPIO_V2_DEB_PER[31:2]: rd_data[DEB_CNT_W-1:0] = deb_per_q;
            GPIO_V2_DEB_EN[31:2]:  rd_data[GPIO_W-1:0]    = deb_en_q;
            default:               rd_data                = '0;
        endcase
    end

    assign bus.gpio_data_o = rd_data;
    assign out_pad_o       = (aux_q & aux_i) | (~aux_q & out_q);
    assign oen_padoe_o     = oe_q;
    assign gpio_inta_o     = inta_q;

    logic unused_bits;
    assign unused_bits = ^{bus.gpio_addr[1:0], bus.gpio_data_i, out_upd};

endmodule

// File: tb/tb_gpio_ctrl_v2.sv
`timescale 1ns/1ps
// Directed self-checking bench for gpio_ctrl_v2 with hand-computed
// expectations.
module tb_gpio_ctrl_v2;
    import gpio_pkg::*;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic [31:0] in_pad_i;
    logic [31:0] aux_i;
    logic [31:0] out_pad_o;
    logic [31:0] oen_padoe_o;
    logic        gpio_inta_o;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    gpio_ctrl_v2_if bus ();

    gpio_ctrl_v2 #(
        .GPIO_W      (32),
        .SYNC_STAGES (2),
        .DEB_CNT_W   (16)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .bus         (bus),
        .in_pad_i    (in_pad_i),
        .aux_i       (aux_i),
        .out_pad_o   (out_pad_o),
        .oen_padoe_o (oen_padoe_o),
        .gpio_inta_o (gpio_inta_o)
    );

    always #10 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.gpio_addr = a;
        #1;
        chk(tag, bus.gpio_data_o, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.gpio_we     = 1'b1;
        bus.gpio_addr   = a;
        bus.gpio_data_i = d;
        @(posedge sys_clk);
        #1;
        bus.gpio_we     = 1'b0;
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        bus.gpio_we     = 1'b0;
        bus.gpio_addr   = '0;
        bus.gpio_data_i = '0;
        in_pad_i        = '0;
        aux_i           = '0;

        // Reset held: every address reads 0, pads idle.
        tick(2);
        for (int a = 0; a <= 'h3C; a += 4) rd($sformatf("rst_rd_%02h", a), 32'(a), 32'h0);
        rd("rst_rd_100", 32'h100, 32'h0);
        chk("rst_out_pad", out_pad_o, 32'h0);
        chk("rst_oen", oen_padoe_o, 32'h0);
        chk("rst_inta", {31'b0, gpio_inta_o}, 32'h0);
        tick(1);
        sys_rst = 1'b1;

        // Default level-low mode with all inputs low latches every bit.
        tick(2);
        rd("ints_level_low", GPIO_V2_INTS, 32'hFFFF_FFFF);
        chk("inta_masked", {31'b0, gpio_inta_o}, 32'h0);
        wr(GPIO_V2_ETRIG, 32'hFFFF_FFFF);
        wr(GPIO_V2_INTS, 32'hFFFF_FFFF);
        rd("ints_w1c_all", GPIO_V2_INTS, 32'h0);

        // Output register and atomic ops.
        wr(GPIO_V2_OUT, 32'hF0);
        wr(GPIO_V2_OUT_SET, 32'h1);
        wr(GPIO_V2_OUT_CLR, 32'h10);
        wr(GPIO_V2_OUT_TGL, 32'h3);
        rd("out_atomic", GPIO_V2_OUT, 32'hE2);
        chk("out_pad_atomic", out_pad_o, 32'hE2);
        rd("out_set_rd0", GPIO_V2_OUT_SET, 32'h0);
        wr(32'h3C, 32'hFFFF_FFFF);
        wr(32'h104, 32'h0);
        rd("out_unmapped_wr", GPIO_V2_OUT, 32'hE2);
        wr(GPIO_V2_OE, 32'hFF);
        chk("oen", oen_padoe_o, 32'hFF);
        aux_i = 32'h1;
        wr(GPIO_V2_AUX, 32'h3);
        rd("aux_rd", GPIO_V2_AUX, 32'h3);
        chk("out_pad_aux", out_pad_o, 32'hE1);
        wr(GPIO_V2_AUX, 32'h0);
        chk("out_pad_noaux", out_pad_o, 32'hE2);

        // Both-edge interrupt on pin 5.
        wr(GPIO_V2_BOTH, 32'h20);
        wr(GPIO_V2_INTE, 32'h20);
        wr(GPIO_V2_CTRL, 32'h1);
        in_pad_i = 32'h20;
        tick(1);
        rd("rise_e1_ints", GPIO_V2_INTS, 32'h0);
        tick(1);
        rd("rise_e2_in", GPIO_V2_IN, 32'h20);
        rd("rise_e2_ints", GPIO_V2_INTS, 32'h0);
        tick(1);
        rd("rise_e3_ints", GPIO_V2_INTS, 32'h20);
        chk("rise_e3_inta", {31'b0, gpio_inta_o}, 32'h0);
        tick(1);
        chk("rise_e4_inta", {31'b0, gpio_inta_o}, 32'h1);
        wr(GPIO_V2_INTS, 32'h20);
        rd("rise_w1c_ints", GPIO_V2_INTS, 32'h0);
        chk("rise_w1c_inta_reg", {31'b0, gpio_inta_o}, 32'h1);
        tick(1);
        chk("rise_w1c_inta_drop", {31'b0, gpio_inta_o}, 32'h0);
        in_pad_i = 32'h0;
        tick(2);
        rd("fall_e2_ints", GPIO_V2_INTS, 32'h0);
        tick(1);
        rd("fall_e3_ints", GPIO_V2_INTS, 32'h20);
        tick(1);
        chk("fall_e4_inta", {31'b0, gpio_inta_o}, 32'h1);
        wr(GPIO_V2_INTS, 32'h20);
        tick(1);
        chk("fall_w1c_inta", {31'b0, gpio_inta_o}, 32'h0);

        // Level-high on pin 0: W1C ineffective while active.
        wr(GPIO_V2_PTRIG, 32'h1);
        wr(GPIO_V2_ETRIG, 32'hFFFF_FFFE);
        in_pad_i = 32'h1;
        tick(3);
        rd("lvl_set", GPIO_V2_INTS, 32'h1);
        chk("lvl_inta_masked", {31'b0, gpio_inta_o}, 32'h0);
        wr(GPIO_V2_INTS, 32'h1);
        rd("lvl_w1c_held", GPIO_V2_INTS, 32'h1);
        in_pad_i = 32'h0;
        tick(3);
        rd("lvl_sticky", GPIO_V2_INTS, 32'h1);
        wr(GPIO_V2_ETRIG, 32'hFFFF_FFFF);
        rd("mode_chg_keeps", GPIO_V2_INTS, 32'h1);
        wr(GPIO_V2_INTS, 32'h1);
        rd("lvl_w1c_clear", GPIO_V2_INTS, 32'h0);

        // Debounce on pin 2, period 4 cycles.
        wr(GPIO_V2_BOTH, 32'h24);
        wr(GPIO_V2_DEB_EN, 32'h4);
        wr(GPIO_V2_DEB_PER, 32'h3);
        rd("deb_per_rd", GPIO_V2_DEB_PER, 32'h3);
        rd("deb_en_rd", GPIO_V2_DEB_EN, 32'h4);
        in_pad_i = 32'h4;
        tick(2);
        in_pad_i = 32'h0;
        rd("glitch_in_a", GPIO_V2_IN, 32'h0);
        tick(1);
        rd("glitch_in_b", GPIO_V2_IN, 32'h0);
        tick(10);
        rd("glitch_in_after", GPIO_V2_IN, 32'h0);
        rd("glitch_ints", GPIO_V2_INTS, 32'h0);
        in_pad_i = 32'h4;
        tick(5);
        rd("hold_in_early", GPIO_V2_IN, 32'h0);
        tick(5);
        rd("hold_in_late", GPIO_V2_IN, 32'h4);
        tick(2);
        rd("hold_ints", GPIO_V2_INTS, 32'h4);

        // Rising edge on pin 5 lands on the same edge as its W1C.
        in_pad_i = 32'h24;
        tick(2);
        wr(GPIO_V2_INTS, 32'h20);
        rd("set_beats_clr", GPIO_V2_INTS, 32'h24);
        tick(1);
        chk("set_beats_clr_inta", {31'b0, gpio_inta_o}, 32'h1);

        // Async reset in the middle of a debounce.
        in_pad_i = 32'h20;
        tick(3);
        #4;
        sys_rst = 1'b0;
        #1;
        chk("arst_out_pad", out_pad_o, 32'h0);
        chk("arst_oen", oen_padoe_o, 32'h0);
        chk("arst_inta", {31'b0, gpio_inta_o}, 32'h0);
        rd("arst_in", GPIO_V2_IN, 32'h0);
        rd("arst_ints", GPIO_V2_INTS, 32'h0);
        rd("arst_out", GPIO_V2_OUT, 32'h0);
        rd("arst_deb_per", GPIO_V2_DEB_PER, 32'h0);
        rd("arst_deb_en", GPIO_V2_DEB_EN, 32'h0);
        tick(1);
        sys_rst = 1'b1;
        tick(2);
        rd("post_rst_in", GPIO_V2_IN, 32'h20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
